// File: rtl/nor_logic_pkg.sv
// Shared definitions for the NOR-built logic unit.
// Function-select codes (3-bit), FSM state type, and NOR2-based helper cells.
package nor_logic_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } state_t;

  // The only primitive cell: 2-input NOR.
  function automatic logic nor2(input logic p, input logic q);
    return ~(p | q);
  endfunction

  // XOR from four NOR2 cells plus one NOR2 inverter.
  function automatic logic xor_nor(input logic p, input logic q);
    logic t, u, v, xn;
    t  = nor2(p, q);
    u  = nor2(p, t);
    v  = nor2(q, t);
    xn = nor2(u, v);
    return nor2(xn, xn);
  endfunction

endpackage

// File: rtl/nor_bitwise.sv
// Combinational bitwise function unit built solely from NOR2 cells.
// Ports:
//   x, z  : WIDTH-bit operands
//   op    : function select (AND, OR, NAND, NOR, XOR, XNOR, NOT x, PASS x)
//   r     : WIDTH-bit result
module nor_bitwise
  import nor_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] z,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic nx, nz, n_or, f_or, f_and, f_nand;
    logic u, v, f_xnor, f_xor, f_pass;
    logic [7:0] f;

    assign nx     = nor2(x[i], x[i]);
    assign nz     = nor2(z[i], z[i]);
    assign n_or   = nor2(x[i], z[i]);
    assign f_or   = nor2(n_or, n_or);
    assign f_and  = nor2(nx, nz);
    assign f_nand = nor2(f_and, f_and);
    // u = ~x & z, v = x & ~z; their NOR is XNOR
    assign u      = nor2(x[i], n_or);
    assign v      = nor2(z[i], n_or);
    assign f_xnor = nor2(u, v);
    assign f_xor  = nor2(f_xnor, f_xnor);
    assign f_pass = nor2(nx, nx);

    // Indexed by op code
    assign f    = {f_pass, nx, f_xnor, f_xor, n_or, f_nand, f_or, f_and};
    assign r[i] = f[op];
  end

endmodule

// File: rtl/nor_logic_unit.sv
// Registered NOR-built logic unit with valid/ready stream and fold mode.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input beat handshake
//   a, b, op            : operands and function select
//   acc_mode, last      : fold a multi-beat stream of a into one result
//   out_valid/out_ready : result handshake
//   y, beats            : result and number of beats folded (saturating)
//   out_parity          : XOR-reduce of y, only with NOR_LOGIC_UNIT_PARITY_EN
module nor_logic_unit
  import nor_logic_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 255,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] beats
`ifdef NOR_LOGIC_UNIT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_l;

  logic             accept, in_accum, load;
  logic [WIDTH-1:0] fn_x, fn_z, fn_r, y_next;
  logic [2:0]       fn_op;
  logic [CNT_W-1:0] cnt_next, beats_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_accum = (state == ST_ACCUM);

  // While folding, the unary ops apply to the incoming word, not to acc.
  always_comb begin
    fn_op = op;
    fn_x  = a;
    fn_z  = b;
    if (in_accum) begin
      fn_op = op_l;
      fn_x  = (op_l == OP_NOTA || op_l == OP_PASS) ? a : acc;
      fn_z  = a;
    end
  end

  nor_bitwise #(.WIDTH(WIDTH)) u_bitwise (
    .x  (fn_x),
    .z  (fn_z),
    .op (fn_op),
    .r  (fn_r)
  );

  always_comb begin
    cnt_next   = (cnt == MAX_CNT) ? cnt : cnt + ONE;
    load       = accept && (in_accum ? last : (!acc_mode || last));
    y_next     = (!in_accum && acc_mode) ? a : fn_r;
    beats_next = in_accum ? cnt_next : ONE;
  end

`ifdef NOR_LOGIC_UNIT_PARITY_EN
  logic par_next;
  always_comb begin
    par_next = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) par_next = xor_nor(par_next, y_next[i]);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      op_l      <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      beats     <= '0;
`ifdef NOR_LOGIC_UNIT_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        y         <= y_next;
        beats     <= beats_next;
`ifdef NOR_LOGIC_UNIT_PARITY_EN
        out_parity <= par_next;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (acc_mode && !last) begin
              acc   <= a;
              cnt   <= ONE;
              op_l  <= op;
              state <= ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            acc <= fn_r;
            cnt <= cnt_next;
            if (last) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
